// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix responder.
//   state_e   : responder FSM states
//   ROWS_IDLE : row-line value when no key is asserted (active-low lines)
//   key_row   : row index field of a key code, bits [3:2]
//   key_col   : column index field of a key code, bits [1:0]
package keypad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBounceIn,
    StHold,
    StBounceOut,
    StGap
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a done flag.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value this cycle (wins over counting)
//   load_value  : cycles until done; a load of N raises done in the Nth cycle after the load
//   done        : high while the count sits at 1, i.e. in the last cycle of the loaded interval
module phase_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/keypad_matrix_responder.sv
// Switch-side emulation of one key of a 4x4 active-low keypad matrix, including contact bounce.
// A command (key_code, hold_cycles) is accepted in IDLE; the responder then walks through
// press bounce, stable hold, release bounce and a mandatory idle gap, driving the selected
// row low whenever the emulated contact is closed and the scanner strobes the key's column.
// Build option: define KEYPAD_BOUNCE_EN for multi-phase bounce; otherwise each bounce stage
// lasts a single cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   columnas[3:0] : column strobes from the scanner, active-low
//   cmd_valid     : command request
//   cmd_ready     : command can be accepted (IDLE only, low the first cycle after reset)
//   key_code[3:0] : [3:2] row index, [1:0] column index
//   hold_cycles   : stable-contact duration, 0 treated as 1
//   abort         : single-cycle release request
//   filas[3:0]    : row lines to the scanner, active-low, registered
//   busy          : any state other than IDLE
//   contact       : current emulated contact state
//   press_count   : completed press-ins, wrapping
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_PERIOD = 16,
  parameter int unsigned BOUNCE_PHASES = 5,  // odd, so bounce-in ends closed and bounce-out open
  parameter int unsigned GAP_CYCLES    = 32,
  parameter int unsigned HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        columnas,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        key_code,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              abort,
  output logic [3:0]        filas,
  output logic              busy,
  output logic              contact,
  output logic [7:0]        press_count
);

  // One timer serves bounce phases, hold and gap, so it must fit the widest of them.
  localparam int unsigned MaxFixed = (BOUNCE_PERIOD > GAP_CYCLES) ? BOUNCE_PERIOD : GAP_CYCLES;
  localparam int unsigned FixedW   = $clog2(MaxFixed + 1);
  localparam int unsigned TimerW   = (HOLD_W > FixedW) ? HOLD_W : FixedW;

  state_e            state_q, state_d;
  logic              cmd_ready_q;
  logic [3:0]        filas_q, filas_d;
  logic [7:0]        press_count_q;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_q;
  logic              accept;
  logic              timer_load;
  logic [TimerW-1:0] timer_value;
  logic              timer_done;

`ifdef KEYPAD_BOUNCE_EN
  localparam int unsigned PhaseW = (BOUNCE_PHASES > 1) ? $clog2(BOUNCE_PHASES) : 1;
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(BOUNCE_PHASES - 1);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              last_phase;

  assign last_phase = (phase_q == LastPhase);
`endif

  assign accept = cmd_valid & cmd_ready_q;

  phase_timer #(
    .WIDTH(TimerW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // Next-state logic; timer loads happen on the edge that enters the timed interval.
  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_value = '0;
`ifdef KEYPAD_BOUNCE_EN
    phase_d     = phase_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBounceIn;
`ifdef KEYPAD_BOUNCE_EN
          timer_load  = 1'b1;
          timer_value = TimerW'(BOUNCE_PERIOD);
          phase_d     = '0;
`endif
        end
      end
      StBounceIn: begin
`ifdef KEYPAD_BOUNCE_EN
        if (timer_done) begin
          timer_load = 1'b1;
          if (last_phase) begin
            state_d     = StHold;
            timer_value = TimerW'(hold_q);
          end else begin
            phase_d     = phase_q + 1'b1;
            timer_value = TimerW'(BOUNCE_PERIOD);
          end
        end
`else
        state_d     = StHold;
        timer_load  = 1'b1;
        timer_value = TimerW'(hold_q);
`endif
      end
      StHold: begin
        if (timer_done) begin
          state_d = StBounceOut;
`ifdef KEYPAD_BOUNCE_EN
          timer_load  = 1'b1;
          timer_value = TimerW'(BOUNCE_PERIOD);
          phase_d     = '0;
`endif
        end
      end
      StBounceOut: begin
`ifdef KEYPAD_BOUNCE_EN
        if (timer_done) begin
          timer_load = 1'b1;
          if (last_phase) begin
            state_d     = StGap;
            timer_value = TimerW'(GAP_CYCLES);
          end else begin
            phase_d     = phase_q + 1'b1;
            timer_value = TimerW'(BOUNCE_PERIOD);
          end
        end
`else
        state_d     = StGap;
        timer_load  = 1'b1;
        timer_value = TimerW'(GAP_CYCLES);
`endif
      end
      StGap: begin
        if (timer_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort jumps straight to the gap from any active contact state.
    if (abort && (state_q == StBounceIn || state_q == StHold || state_q == StBounceOut)) begin
      state_d     = StGap;
      timer_load  = 1'b1;
      timer_value = TimerW'(GAP_CYCLES);
    end
  end

  // Contact alternates per phase: even phases closed on press, open on release.
  always_comb begin
    contact = 1'b0;
    unique case (state_q)
`ifdef KEYPAD_BOUNCE_EN
      StBounceIn:  contact = ~phase_q[0];
      StBounceOut: contact = phase_q[0];
`else
      StBounceIn:  contact = 1'b1;
      StBounceOut: contact = 1'b0;
`endif
      StHold:      contact = 1'b1;
      default:     contact = 1'b0;
    endcase
  end

  always_comb begin
    filas_d = ROWS_IDLE;
    filas_d[key_row(key_q)] = ~(contact & ~columnas[key_col(key_q)]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      filas_q       <= ROWS_IDLE;
      press_count_q <= '0;
      key_q         <= '0;
      hold_q        <= HOLD_W'(1);
`ifdef KEYPAD_BOUNCE_EN
      phase_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == StIdle);
      filas_q     <= filas_d;
`ifdef KEYPAD_BOUNCE_EN
      phase_q     <= phase_d;
`endif
      if (accept) begin
        key_q  <= key_code;
        hold_q <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
      end
      if (state_d == StHold && state_q != StHold) begin
        press_count_q <= press_count_q + 8'd1;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = (state_q != StIdle);
  assign filas       = filas_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Self-checking bench for keypad_matrix_responder (default parameters). Expected contact values
// for a whole press are queued when the command is issued and popped one per clock.
module tb_keypad_matrix_responder;

  localparam int BP  = 16;
  localparam int PH  = 5;
  localparam int GAP = 32;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BounceLen = BP * PH;
  localparam int AbortIdx  = BP + 3;  // inside the second press-bounce phase
`else
  localparam int BounceLen = 1;
  localparam int AbortIdx  = 0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  columnas;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  key_code;
  logic [15:0] hold_cycles;
  logic        abort;
  logic [3:0]  filas;
  logic        busy;
  logic        contact;
  logic [7:0]  press_count;

  int       tests;
  int       fails;
  bit       exp_q[$];
  bit [7:0] exp_pc;
  bit       prev_c;
  bit [3:0] prev_cols;

  keypad_matrix_responder dut (
    .clk        (clk),
    .reset      (reset),
    .columnas   (columnas),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .key_code   (key_code),
    .hold_cycles(hold_cycles),
    .abort      (abort),
    .filas      (filas),
    .busy       (busy),
    .contact    (contact),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Matrix behaviour: the key's row is pulled low while closed and its column is strobed.
  function automatic logic [3:0] rows_model(input bit c, input bit [3:0] cols,
                                            input bit [3:0] key);
    logic [3:0] r;
    r = 4'b1111;
    if (c && !cols[key[1:0]]) r[key[3:2]] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] cols_for(input int mode, input bit [3:0] base, input int cyc);
    logic [3:0] rot [4];
    rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    return (mode == 0) ? base : rot[(cyc / 4) % 4];
  endfunction

  task automatic push_expected(input int hold);
    int h;
    h = (hold == 0) ? 1 : hold;
`ifdef KEYPAD_BOUNCE_EN
    for (int p = 0; p < PH; p++) repeat (BP) exp_q.push_back(p % 2 == 0);
`else
    exp_q.push_back(1'b1);
`endif
    repeat (h) exp_q.push_back(1'b1);
`ifdef KEYPAD_BOUNCE_EN
    for (int p = 0; p < PH; p++) repeat (BP) exp_q.push_back(p % 2 == 1);
`else
    exp_q.push_back(1'b0);
`endif
    repeat (GAP) exp_q.push_back(1'b0);
  endtask

  task automatic do_press(input bit [3:0] key, input int hold, input bit [3:0] cols,
                          input int mode, input bit keep_valid, input int abort_at,
                          input int rst_at);
    int guard;
    int idx;
    bit e;
    key_code    = key;
    hold_cycles = 16'(hold);
    columnas    = cols_for(mode, cols, 0);
    cmd_valid   = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 2000) begin
      step();
      guard++;
    end
    chk("accept_wait", 32'(guard < 2000), 1);
    prev_c    = 1'b0;
    prev_cols = columnas;
    step();  // acceptance edge
    if (!keep_valid) cmd_valid = 1'b0;
    push_expected(hold);
    if (abort_at < 0 || abort_at >= BounceLen) exp_pc++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("contact", contact, e);
      chk("busy", busy, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("filas", filas, rows_model(prev_c, prev_cols, key));
      prev_c    = e;
      columnas  = cols_for(mode, cols, idx + 1);
      prev_cols = columnas;
      if (idx == abort_at) begin
        abort = 1'b1;
        exp_q.delete();
        repeat (GAP) exp_q.push_back(1'b0);
      end
      if (idx == rst_at) begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        step();
        exp_q.delete();
        exp_pc = 0;
        chk("rst_filas", filas, 4'hF);
        chk("rst_contact", contact, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_count", press_count, 0);
        reset = 1'b0;
        step();
        chk("rst_ready_rise", cmd_ready, 1);
        return;
      end
      step();
      abort = 1'b0;
      idx++;
    end
    chk("end_ready", cmd_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_contact", contact, 0);
    chk("end_filas", filas, 4'hF);
    chk("press_count", press_count, exp_pc);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    exp_pc      = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    abort       = 1'b0;
    columnas    = 4'hF;
    key_code    = 4'h0;
    hold_cycles = 16'd0;
    step();
    step();
    chk("reset_filas", filas, 4'hF);
    chk("reset_contact", contact, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", cmd_ready, 0);
    chk("reset_count", press_count, 0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", cmd_ready, 1);

    // Key 6 (row 1, column 2) with its column held strobed.
    do_press(4'h6, 100, 4'b1011, 0, 1'b0, -1, -1);
    // Key F under a rotating column scan; cmd_valid left high so the next command follows.
    do_press(4'hF, 20, 4'b1111, 1, 1'b1, -1, -1);
    do_press(4'h9, 5, 4'b1101, 0, 1'b0, -1, -1);
    // Abort during press bounce.
    do_press(4'h3, 50, 4'b0111, 0, 1'b0, AbortIdx, -1);
    // Zero hold with an unstrobed column: no row may go low.
    do_press(4'h5, 0, 4'b1111, 0, 1'b0, -1, -1);
    // Reset in the middle of HOLD.
    do_press(4'hA, 40, 4'b1011, 0, 1'b0, -1, BounceLen + 10);
    // 256 back-to-back presses wrap the counter.
    for (int n = 0; n < 256; n++) begin
      do_press(4'h1, 0, 4'b1101, 0, n != 255, -1, -1);
    end
    chk("wrap_count", press_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
